// File: rtl/exc_mdu.sv
// EXC-stage multi-cycle multiply/divide unit producing a 64-bit HI/LO result.
// Optional macro MDU_EARLY_OUT_EN skips the divide iterations for trivial divides.
module exc_mdu #(
  parameter int MUL_LAT = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        exception_flush,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  output logic        stall_req,
  output logic        res_valid,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

  state_t      state, state_next;
  logic [4:0]  count;
  logic        is_signed, sign_a, sign_b;
  logic [31:0] a_q, b_q, mag_b;
  logic [63:0] rq;
  logic        accept, early;
  logic [31:0] mag_a_in, mag_b_in;
  logic [63:0] mul_a, mul_b, product;
  logic [64:0] shifted;
  logic [32:0] diff;
  logic [63:0] rq_next;
  logic [31:0] quo, rem, div_hi, div_lo;

  assign accept    = (state == IDLE) && start && !exception_flush;
  assign stall_req = accept || (state == MUL) || (state == DIV);
  assign res_valid = (state == DONE) && !exception_flush;
  assign busy      = (state != IDLE);

  assign mag_a_in = (!op[0] && src_a[31]) ? -src_a : src_a;
  assign mag_b_in = (!op[0] && src_b[31]) ? -src_b : src_b;

`ifdef MDU_EARLY_OUT_EN
  assign early = op[1] && ((src_b == 32'd0) || (mag_a_in < mag_b_in));
`else
  assign early = 1'b0;
`endif

  // Sign-extending to 64 bits gives the same low 64 bits as a 33x33 signed product
  assign mul_a   = {{32{is_signed & a_q[31]}}, a_q};
  assign mul_b   = {{32{is_signed & b_q[31]}}, b_q};
  assign product = mul_a * mul_b;

  assign shifted = {rq, 1'b0};
  assign diff    = shifted[64:32] - {1'b0, mag_b};

  always_comb begin
    rq_next = shifted[63:0];
    if (!diff[32]) rq_next = {diff[31:0], shifted[31:1], 1'b1};
  end

  // Fix-up uses the post-iteration value so hi/lo load on the edge into DONE
  assign quo    = rq_next[31:0];
  assign rem    = rq_next[63:32];
  assign div_lo = (b_q == 32'd0) ? 32'hFFFF_FFFF : ((sign_a ^ sign_b) ? -quo : quo);
  assign div_hi = (b_q == 32'd0) ? a_q : (sign_a ? -rem : rem);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (exception_flush) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE: if (start) state_next = op[1] ? (early ? DONE : DIV) : MUL;
        MUL:  if (count == 5'd0) state_next = DONE;
        DIV:  if (count == 5'd0) state_next = DONE;
        DONE: state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count     <= 5'd0;
      hi        <= 32'd0;
      lo        <= 32'd0;
      rq        <= 64'd0;
      a_q       <= 32'd0;
      b_q       <= 32'd0;
      mag_b     <= 32'd0;
      is_signed <= 1'b0;
      sign_a    <= 1'b0;
      sign_b    <= 1'b0;
    end else if (!exception_flush) begin
      case (state)
        IDLE: begin
          if (start) begin
            a_q       <= src_a;
            b_q       <= src_b;
            mag_b     <= mag_b_in;
            is_signed <= !op[0];
            sign_a    <= !op[0] && src_a[31];
            sign_b    <= !op[0] && src_b[31];
            rq        <= {32'd0, mag_a_in};
            count     <= op[1] ? 5'd31 : 5'(MUL_LAT - 1);
            if (early) begin
              hi <= src_a;
              lo <= (src_b == 32'd0) ? 32'hFFFF_FFFF : 32'd0;
            end
          end
        end
        MUL: begin
          count <= count - 5'd1;
          if (count == 5'd0) begin
            hi <= product[63:32];
            lo <= product[31:0];
          end
        end
        DIV: begin
          rq    <= rq_next;
          count <= count - 5'd1;
          if (count == 5'd0) begin
            hi <= div_hi;
            lo <= div_lo;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_exc_mdu.sv
// Self-checking bench for exc_mdu: directed table, flush/back-to-back/reset
// sequences, and random ops against an arithmetic reference model.
module tb_exc_mdu;

  localparam int MUL_LAT = 2;

  logic        clk = 1'b0;
  logic        rst, exception_flush, start;
  logic [1:0]  op;
  logic [31:0] src_a, src_b;
  logic        stall_req, res_valid, busy;
  logic [31:0] hi, lo;

  int checks = 0;
  int errors = 0;
  int pulses = 0;

  exc_mdu #(.MUL_LAT(MUL_LAT)) dut (
    .clk(clk), .rst(rst), .exception_flush(exception_flush), .start(start),
    .op(op), .src_a(src_a), .src_b(src_b), .stall_req(stall_req),
    .res_valid(res_valid), .hi(hi), .lo(lo), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (res_valid) pulses++;

  typedef struct {
    string       name;
    logic [1:0]  op;
    logic [31:0] a, b, hi, lo;
  } vec_t;

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%h expected=%h", name, actual, expected);
    end
  endtask

  function automatic logic [63:0] ref_model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    logic [63:0] ua, ub, p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    if (o == 2'd0) begin
      q = sa * sb;
      return q;
    end
    if (o == 2'd1) begin
      p = ua * ub;
      return p;
    end
    if (b == 32'd0) return {a, 32'hFFFF_FFFF};
    if (o == 2'd2) begin
      q = sa / sb;
      r = sa % sb;
    end else begin
      q = longint'(ua / ub);
      r = longint'(ua % ub);
    end
    return {r[31:0], q[31:0]};
  endfunction

  function automatic int exp_stall(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] ma, mb;
    if (!o[1]) return MUL_LAT + 1;
    ma = (!o[0] && a[31]) ? -a : a;
    mb = (!o[0] && b[31]) ? -b : b;
`ifdef MDU_EARLY_OUT_EN
    if (b == 32'd0 || ma < mb) return 1;
`endif
    return 33;
  endfunction

  // Drives one instruction and follows it until its single result cycle
  task automatic apply_stimulus(input string name, input logic [1:0] o, input logic [31:0] a,
                                input logic [31:0] b, input logic [31:0] exp_hi,
                                input logic [31:0] exp_lo, input int stall_exp, input bit keep);
    int stalls;
    bit done;
    op = o; src_a = a; src_b = b; start = 1'b1;
    stalls = 0;
    done = 1'b0;
    for (int i = 0; i < 200; i++) begin
      #1;
      if (res_valid) begin
        done = 1'b1;
        break;
      end
      if (stall_req) stalls++;
      @(negedge clk);
    end
    check_output({name, " done"}, 32'(done), 32'd1);
    if (done) begin
      check_output({name, " hi"}, hi, exp_hi);
      check_output({name, " lo"}, lo, exp_lo);
      check_output({name, " stalls"}, stalls, stall_exp);
    end
    if (!keep) start = 1'b0;
    @(negedge clk);
    #1;
    check_output({name, " single pulse"}, 32'(res_valid), 32'd0);
    check_output({name, " no reaccept"}, 32'(busy), 32'd0);
  endtask

  initial begin
    vec_t tbl[7];
    logic [63:0] r;
    logic [31:0] prior_hi, prior_lo, a, b;
    logic [1:0]  o;
    int p0;

    tbl[0] = '{"MULT neg", 2'd0, 32'hFFFF_FFFF, 32'h2, 32'hFFFF_FFFF, 32'hFFFF_FFFE};
    tbl[1] = '{"MULTU", 2'd1, 32'hFFFF_FFFF, 32'h2, 32'h1, 32'hFFFF_FFFE};
    tbl[2] = '{"DIV -7/2", 2'd2, 32'hFFFF_FFF9, 32'h2, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
    tbl[3] = '{"DIVU 100/7", 2'd3, 32'd100, 32'd7, 32'd2, 32'd14};
    tbl[4] = '{"DIVU 5/0", 2'd3, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF};
    tbl[5] = '{"DIVU 3/7", 2'd3, 32'd3, 32'd7, 32'd3, 32'd0};
    tbl[6] = '{"DIV min/-1", 2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000};

    rst = 1'b1; exception_flush = 1'b0; start = 1'b0;
    op = 2'd0; src_a = 32'd0; src_b = 32'd0;
    repeat (2) @(negedge clk);
    #1;
    check_output("reset stall", 32'(stall_req), 32'd0);
    check_output("reset valid", 32'(res_valid), 32'd0);
    check_output("reset busy", 32'(busy), 32'd0);
    check_output("reset hi", hi, 32'd0);
    check_output("reset lo", lo, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    foreach (tbl[i])
      apply_stimulus(tbl[i].name, tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].hi, tbl[i].lo,
                     exp_stall(tbl[i].op, tbl[i].a, tbl[i].b), 1'b0);
    prior_hi = tbl[6].hi;
    prior_lo = tbl[6].lo;

    // Abort a divide part-way through its iterations
    p0 = pulses;
    op = 2'd3; src_a = 32'd100; src_b = 32'd7; start = 1'b1;
    repeat (11) @(negedge clk);
    exception_flush = 1'b1;
    @(negedge clk);
    exception_flush = 1'b0;
    start = 1'b0;
    #1;
    check_output("flush stall", 32'(stall_req), 32'd0);
    check_output("flush busy", 32'(busy), 32'd0);
    check_output("flush hi", hi, prior_hi);
    check_output("flush lo", lo, prior_lo);
    repeat (40) @(negedge clk);
    check_output("flush no pulse", pulses - p0, 32'd0);
    apply_stimulus("MULTU 3x4", 2'd1, 32'd3, 32'd4, 32'd0, 32'd12, MUL_LAT + 1, 1'b0);

    // Start held high across two consecutive instructions
    p0 = pulses;
    apply_stimulus("b2b MULT", 2'd0, 32'd5, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFF1, MUL_LAT + 1, 1'b1);
    apply_stimulus("b2b DIVU", 2'd3, 32'd1000, 32'd33, 32'd10, 32'd30, 33, 1'b0);
    check_output("b2b pulses", pulses - p0, 32'd2);

    for (int n = 0; n < 40; n++) begin
      o = 2'($urandom_range(0, 3));
      a = $urandom;
      case ($urandom_range(0, 7))
        0: b = 32'd0;
        1: b = $urandom_range(1, 20);
        2: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        3: b = a + $urandom_range(1, 5);
        default: b = $urandom;
      endcase
      r = ref_model(o, a, b);
      apply_stimulus($sformatf("rand%0d op%0d", n, o), o, a, b, r[63:32], r[31:0],
                     exp_stall(o, a, b), 1'b0);
    end

    // Reset in the middle of a multiply
    op = 2'd0; src_a = 32'd7; src_b = 32'd9; start = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    start = 1'b0;
    @(negedge clk);
    #1;
    check_output("midrst busy", 32'(busy), 32'd0);
    check_output("midrst stall", 32'(stall_req), 32'd0);
    check_output("midrst hi", hi, 32'd0);
    check_output("midrst lo", lo, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/exc_mdu.md
Name: exc_mdu

Overview:
- Multi-cycle multiply/divide unit in the EXC stage. It consumes the operands and op select registered by the ID2→EXC pipeline register.
- It holds the pipeline with a stall request while it computes a 64-bit HI/LO result, then presents the result for exactly one cycle so EXC can forward it to the HI/LO write path.
- An exception flush aborts any operation in flight.

Parameters:
- MUL_LAT, default 2: number of MUL-state cycles before the multiply result is presented; legal range 1-8.

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- exception_flush  in  1  abort current op and return to IDLE
- start  in  1  EXC holds a valid mul/div instruction; held high until the instruction leaves EXC
- op  in  2  operation: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU; sampled only on accept
- src_a  in  32  rs operand (dividend or multiplicand); sampled only on accept
- src_b  in  32  rt operand (divisor or multiplier); sampled only on accept
- stall_req  out  1  hold pipeline at EXC and upstream
- res_valid  out  1  hi/lo valid this cycle
- hi  out  32  MULT: product[63:32]; DIV: remainder
- lo  out  32  MULT: product[31:0]; DIV: quotient
- busy  out  1  state != IDLE

Behaviour:
- Reset: state=IDLE, res_valid=0, hi=0, lo=0, counter=0, busy=0.
- States:
  - IDLE: when start=1 and exception_flush=0, accept. Latch op, the operand magnitudes (|x| for signed ops) and the result sign flags. Go to MUL (op[1]=0, counter=MUL_LAT-1) or DIV (op[1]=1, counter=31).
  - MUL: the registered product is computed as a signed 33×33 product on sign-extended operands, or unsigned on zero-extended operands. Decrement counter; at 0 go to DONE.
  - DIV: one restoring iteration per cycle on a 64-bit {rem,quo} shift register. Decrement counter; at 0 go to DONE.
  - DONE: res_valid=1, hi/lo driven with the final result, then go to IDLE unconditionally. The still-asserted start in this cycle must not re-accept.
- stall_req:
  - Combinational: (state==IDLE & start & !exception_flush) | state==MUL | state==DIV.
  - Low in DONE, so the instruction leaves EXC at the DONE edge.
- Latency: total cycles the instruction spends in EXC is MUL_LAT+2 for MULT/MULTU, 34 for DIV/DIVU.
- Signed divide fix-up (applied in DONE): quotient negated if sign(a)^sign(b); remainder takes the sign of a.
- Special cases:
  - Divisor 0: lo=0xFFFFFFFF, hi=src_a as latched (signed or unsigned), overriding the fix-up.
  - 0x80000000 / 0xFFFFFFFF signed: lo=0x80000000, hi=0; natural wrap, no exception.
- hi/lo hold their last values outside DONE; they update only on the DONE edge.
- exception_flush, any state: next state IDLE, res_valid=0, hi/lo unchanged, no accept in that cycle. A flush in DONE still leaves hi/lo updated only if DONE was reached before the flush edge.
- rst mid-operation: same as the reset values above.
- start deasserted mid-operation (never legal without a flush): ignored; the op runs to completion.

Optional Feature:
- Macro MDU_EARLY_OUT_EN.
- Defined: on accept of DIV/DIVU with src_b==0 or |src_a|<|src_b|, go directly IDLE→DONE with lo=0 (or 0xFFFFFFFF for divide-by-zero) and hi=src_a. Total EXC occupancy is 2 cycles; stall_req is high for 1 cycle.
- Undefined: all divides take 34 cycles; results are identical.

Test Plan:
- MULT a=0xFFFFFFFF b=0x00000002, MUL_LAT=2 → stall_req high 3 cycles, res_valid 1 cycle, hi=0xFFFFFFFF lo=0xFFFFFFFE.
- MULTU a=0xFFFFFFFF b=0x00000002 → hi=0x00000001 lo=0xFFFFFFFE.
- DIV a=0xFFFFFFF9 (−7) b=0x00000002 → after 33 stall cycles hi=0xFFFFFFFF lo=0xFFFFFFFD.
- DIVU a=100 b=7 → lo=0x0000000E hi=0x00000002; DIVU a=5 b=0 → lo=0xFFFFFFFF hi=0x00000005; DIV a=0x80000000 b=0xFFFFFFFF → lo=0x80000000 hi=0.
- Start DIVU a=100 b=7, assert exception_flush at iteration 10 → next cycle state IDLE, stall_req=0, res_valid never pulses, hi/lo retain prior values; a new MULTU 3×4 then gives lo=12 hi=0.
- Back-to-back MULT then DIVU with start held across both → exactly one res_valid per op, no double accept in DONE. With MDU_EARLY_OUT_EN, DIVU 3/7 → 1 stall cycle, lo=0 hi=3.
